inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue.sv | 73 +++++++
 tb/tb_inst_fetch_queue.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: single-outstanding instruction fetcher feeding a first-word fall-through queue.
module inst_fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_data,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  input  logic                     deq_ready,
  output logic                     inst_valid,
  output logic [31:0]              inst_out,
  output logic [XLEN-1:0]          inst_pc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_next;
  logic [31:0] mem_data [DEPTH];
  logic [XLEN-1:0] mem_pc [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0] count_next;
  logic stale, ack_w, enq, deq, go;
  assign ack_w = state == WAIT && imem_ack;
  assign enq = ack_w && !stale;
  assign deq = inst_valid && deq_ready;
  assign count_next = count + CW'(enq) - CW'(deq);
  // A new request is only issued when its response is guaranteed a free slot.
  assign go = !redirect && count_next < FULL;
  assign imem_addr = fetch_pc;
  assign inst_valid = count != '0;
  assign inst_out = mem_data[rd_ptr];
  assign inst_pc = mem_pc[rd_ptr];
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state == IDLE ? (go ? REQ : IDLE) :
                 state == REQ  ? WAIT :
                 imem_ack      ? (go ? REQ : IDLE) : WAIT;
  end
  always_comb begin
    imem_req = state == REQ;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fetch_pc <= RESET_PC;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      stale <= 1'b0;
    end else begin
      fetch_pc <= redirect ? (redirect_pc & ~XLEN'(3)) : state == REQ ? fetch_pc + XLEN'(4) : fetch_pc;
      stale <= ack_w ? 1'b0 : (redirect && state != IDLE) ? 1'b1 : stale;
      count <= redirect ? '0 : count_next;
      wr_ptr <= redirect ? '0 : wr_ptr + PW'(enq);
      rd_ptr <= redirect ? '0 : rd_ptr + PW'(deq);
    end
  // In a non-stale WAIT, fetch_pc has already moved one word past the request address.
  always_ff @(posedge clk)
    if (enq && !redirect) begin
      mem_data[wr_ptr] <= imem_data;
      mem_pc[wr_ptr] <= fetch_pc - XLEN'(4);
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed scoreboard bench with a 1-cycle memory model for inst_fetch_queue.
module tb_inst_fetch_queue;
  typedef struct packed {logic [31:0] d; logic [31:0] pc;} ent_t;
  logic clk = 0, rst = 1;
  logic imem_req, imem_ack = 0, redirect = 0, deq_ready = 0, inst_valid;
  logic [31:0] imem_addr, imem_data = 0, redirect_pc = 0, inst_out, inst_pc;
  logic [2:0] count;
  logic imem_req2, ack2 = 0, inst_valid2, zero1 = 0, one1 = 1;
  logic [31:0] imem_addr2, inst_out2, inst_pc2, zero32 = 0;
  logic [2:0] count2;
  int n_chk = 0, n_fail = 0, nreq = 0, nreq2 = 0, phase = 0, phase2 = 0;
  logic stale_m = 0, mem_hold = 0, late_ack = 0, forced_en = 0;
  logic [31:0] forced_data = 0, pend_addr = 0, m_pc = 0, m_pc2 = 32'hFFFFFFFC, a2_0 = 0, a2_1 = 0;
  ent_t exp_q[$];

  inst_fetch_queue dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .redirect(redirect), .redirect_pc(redirect_pc), .deq_ready(deq_ready),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc), .count(count)
  );
  inst_fetch_queue #(.RESET_PC(32'hFFFFFFFC)) dut2 (
    .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(ack2),
    .imem_data(zero32), .redirect(zero1), .redirect_pc(zero32), .deq_ready(one1),
    .inst_valid(inst_valid2), .inst_out(inst_out2), .inst_pc(inst_pc2), .count(count2)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic ar;
    ent_t e;
    ar = phase == 2 && !mem_hold;
    imem_ack = ar || late_ack;
    imem_data = forced_en ? forced_data : f(pend_addr);
    ack2 = phase2 == 2;
    if (inst_valid && deq_ready) begin
      chk("sb_has_entry", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("inst_out", inst_out, e.d);
        chk("inst_pc", inst_pc, e.pc);
      end
    end
    if (ar) begin
      if (!stale_m && !redirect) exp_q.push_back('{d: imem_data, pc: pend_addr});
      stale_m = 0;
      phase = 0;
    end else if (redirect && phase != 0) stale_m = 1;
    if (phase == 1) phase = 2;
    if (ack2) phase2 = 0; else if (phase2 == 1) phase2 = 2;
    if (redirect) begin
      exp_q.delete();
      m_pc = redirect_pc & ~32'h3;
    end
    @(posedge clk); #1;
    if (imem_req) begin
      chk("imem_addr", imem_addr, m_pc);
      pend_addr = imem_addr;
      m_pc += 4;
      phase = 1;
      nreq++;
    end
    if (imem_req2) begin
      chk("imem_addr2", imem_addr2, m_pc2);
      m_pc2 += 4;
      phase2 = 1;
      nreq2++;
      if (nreq2 == 1) a2_0 = imem_addr2;
      if (nreq2 == 2) a2_1 = imem_addr2;
    end
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
    chk("occupancy", 32'((int'(count) + int'(phase != 0)) <= 4), 1);
  endtask

  task automatic do_reset();
    #2 rst = 0;
    redirect = 0; deq_ready = 0; mem_hold = 0; late_ack = 0; forced_en = 0;
    #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_count", 32'(count), 0);
    phase = 0; phase2 = 0; stale_m = 0; exp_q.delete();
    m_pc = 0; m_pc2 = 32'hFFFFFFFC; nreq2 = 0; imem_ack = 0; ack2 = 0;
    @(posedge clk); #3 rst = 1;
  endtask

  initial begin
    do_reset();
    // Streaming with a 1-cycle memory: one request every other cycle.
    deq_ready = 1;
    tick();
    chk("first_req", 32'(imem_req), 1);
    chk("first_addr", imem_addr, 0);
    for (int i = 1; i < 12; i++) begin
      tick();
      chk("t1_alt_req", 32'(imem_req), 32'(i % 2 == 0));
      chk("t1_cnt_le1", 32'(count <= 1), 1);
    end
    // Back-pressure fills exactly DEPTH entries.
    do_reset();
    nreq = 0;
    for (int i = 0; i < 14; i++) tick();
    chk("t2_nreq", nreq, 4);
    chk("t2_count", 32'(count), 4);
    chk("t2_idle_req", 32'(imem_req), 0);
    deq_ready = 1; tick(); deq_ready = 0;
    chk("t2_count3", 32'(count), 3);
    chk("t2_req", 32'(imem_req), 1);
    chk("t2_addr", imem_addr, 32'h10);
    // Redirect while waiting: the late word is dropped.
    mem_hold = 1; tick();
    redirect = 1; redirect_pc = 32'h103; tick(); redirect = 0;
    chk("t3_flush", 32'(count), 0);
    mem_hold = 0; forced_en = 1; forced_data = 32'hDEADBEEF; tick(); forced_en = 0;
    chk("t3_discard", 32'(count), 0);
    chk("t3_req", 32'(imem_req), 1);
    chk("t3_addr", imem_addr, 32'h100);
    // Redirect coinciding with ack and dequeue at count 2.
    for (int i = 0; i < 20 && !(count == 2 && phase == 2); i++) tick();
    chk("t4_setup", 32'(count == 2 && phase == 2), 1);
    deq_ready = 1; redirect = 1; redirect_pc = 32'h200; tick(); deq_ready = 0; redirect = 0;
    chk("t4_count", 32'(count), 0);
    chk("t4_valid", 32'(inst_valid), 0);
    chk("t4_idle", 32'(imem_req), 0);
    tick();
    chk("t4_req", 32'(imem_req), 1);
    chk("t4_addr", imem_addr, 32'h200);
    // Redirect during the request cycle makes its response stale.
    redirect = 1; redirect_pc = 32'h302; tick(); redirect = 0;
    tick();
    chk("t5_count", 32'(count), 0);
    chk("t5_req", 32'(imem_req), 1);
    chk("t5_addr", imem_addr, 32'h300);
    // Redirect while idle on a full queue.
    for (int i = 0; i < 16; i++) tick();
    chk("t6_full", 32'(count), 4);
    chk("t6_full_idle", 32'(imem_req), 0);
    redirect = 1; redirect_pc = 32'h400; tick(); redirect = 0;
    chk("t6_count", 32'(count), 0);
    chk("t6_idle", 32'(imem_req), 0);
    tick();
    chk("t6_req", 32'(imem_req), 1);
    chk("t6_addr", imem_addr, 32'h400);
    // Reset in WAIT with a non-empty queue, then a late ack after release.
    tick(); tick();
    mem_hold = 1; tick();
    chk("t7_pre_valid", 32'(inst_valid), 1);
    do_reset();
    late_ack = 1; tick(); late_ack = 0;
    chk("t7_first_req", 32'(imem_req), 1);
    chk("t7_addr", imem_addr, 0);
    chk("t7_count", 32'(count), 0);
    deq_ready = 1;
    for (int i = 0; i < 8; i++) tick();
    chk("wrap0", a2_0, 32'hFFFFFFFC);
    chk("wrap1", a2_1, 32'h00000000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
